// File: rtl/decode_stage.sv
// Instruction decode stage with a two-entry (output + skid) elastic buffer.
// Decodes if_instr combinationally and registers the fields into OUT, or into
// SKID when OUT is stalled, so id_ready never depends on ex_ready in the same cycle.
// Ports:
//   clk, rst (async, active-low)
//   if_valid/if_instr/if_pc/id_ready : fetch-side handshake and payload
//   flush                            : drop everything held and incoming
//   ex_valid/ex_ready                : execute-side handshake
//   firstLevelDecode .. illegal, pc  : registered decoded fields of OUT
module decode_stage #(
  parameter int unsigned PC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  output logic            id_ready,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [1:0]      firstLevelDecode,
  output logic            specialEncoding,
  output logic [3:0]      secondLevelDecode,
  output logic [2:0]      aluFunctions,
  output logic [3:0]      branchInstruction,
  output logic [3:0]      rd,
  output logic [3:0]      rs1,
  output logic [15:0]     imm,
  output logic [PC_W-1:0] pc,
  output logic            illegal
);

  localparam int unsigned IMM_W = 16;
  localparam int unsigned RAW_W = 14;

  typedef struct packed {
    logic [1:0]      fld;
    logic            spec;
    logic [3:0]      sec;
    logic [2:0]      alu;
    logic [3:0]      br;
    logic [3:0]      rd;
    logic [3:0]      rs1;
    logic [IMM_W-1:0] imm;
    logic            illegal;
    logic [PC_W-1:0] pc;
  } dec_t;

  dec_t dec_c;
  dec_t out_q, out_d;
  dec_t skid_q, skid_d;
  logic out_valid_q, out_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic id_ready_q, id_ready_d;
  logic in_xfer_c;
  logic is_branch_c;

  // Combinational field extraction from the incoming word.
  always_comb begin
    is_branch_c   = (if_instr[31:30] == 2'b11);
    dec_c         = '0;
    dec_c.fld     = if_instr[31:30];
    dec_c.spec    = if_instr[29];
    dec_c.sec     = if_instr[28:25];
    dec_c.alu     = if_instr[24:22];
    dec_c.br      = is_branch_c ? if_instr[21:18] : 4'b0000;
    dec_c.rd      = is_branch_c ? 4'b0000 : if_instr[21:18];
    dec_c.rs1     = if_instr[17:14];
    // Sign bit is instr[13] only when the special-encoding bit requests it.
    dec_c.imm     = {{(IMM_W-RAW_W){if_instr[13] & if_instr[29]}}, if_instr[13:0]};
    dec_c.illegal = is_branch_c & if_instr[29];
    dec_c.pc      = if_pc;
  end

  // Next-state for OUT/SKID; flush overrides every other update.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    in_xfer_c    = if_valid & id_ready_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || ex_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_xfer_c) begin
        out_d       = dec_c;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer_c) begin
      // OUT stalled: park the new instruction in SKID.
      skid_d       = dec_c;
      skid_valid_d = 1'b1;
    end

    id_ready_d = ~skid_valid_d;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      id_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      id_ready_q   <= id_ready_d;
    end
  end

  assign id_ready          = id_ready_q;
  assign ex_valid          = out_valid_q;
  assign firstLevelDecode  = out_q.fld;
  assign specialEncoding   = out_q.spec;
  assign secondLevelDecode = out_q.sec;
  assign aluFunctions      = out_q.alu;
  assign branchInstruction = out_q.br;
  assign rd                = out_q.rd;
  assign rs1               = out_q.rs1;
  assign imm               = out_q.imm;
  assign illegal           = out_q.illegal;
  assign pc                = out_q.pc;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: PC_W, default 16, width of the program-counter field carried alongside each instruction.
REQ-002 Port: clk  input  1  single clock for all state; rising-edge triggered.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: if_valid  input  1  fetch presents a valid instruction.
REQ-005 Port: if_instr  input  32  raw instruction word.
REQ-006 Port: if_pc  input  PC_W  address of if_instr.
REQ-007 Port: id_ready  output  1  stage accepts an instruction this cycle.
REQ-008 Port: flush  input  1  discard all held and incoming instructions.
REQ-009 Port: ex_ready  input  1  execute consumes the output this cycle.
REQ-010 Port: ex_valid  output  1  decoded outputs are valid.
REQ-011 Port: firstLevelDecode  output  2  instr[31:30].
REQ-012 Port: specialEncoding  output  1  instr[29].
REQ-013 Port: secondLevelDecode  output  4  instr[28:25].
REQ-014 Port: aluFunctions  output  3  instr[24:22].
REQ-015 Port: branchInstruction  output  4  instr[21:18] when instr[31:30]==2'b11, else 4'b0000.
REQ-016 Port: rd  output  4  instr[21:18]; forced to 4'b0000 when instr[31:30]==2'b11.
REQ-017 Port: rs1  output  4  instr[17:14].
REQ-018 Port: imm  output  16  instr[13:0], sign-extended when instr[29]==1, else zero-extended.
REQ-019 Port: pc  output  PC_W  if_pc captured with the instruction.
REQ-020 Port: illegal  output  1  set when instr[31:30]==2'b11 and instr[29]==1.

Function
REQ-021 Transfer in occurs when if_valid and id_ready are both high on a rising edge; transfer out occurs when ex_valid and ex_ready are both high.
REQ-022 Two storage entries: output register (OUT) and skid register (SKID), each holding a valid bit plus all decoded fields.
REQ-023 Decode is combinational from if_instr; the decoded fields are registered into OUT or SKID. Latency is exactly one cycle from input transfer to ex_valid.
REQ-024 id_ready shall be the registered inverse of SKID valid; it carries no combinational path from ex_ready.
REQ-025 OUT update rule: if OUT is empty or is transferring out, OUT loads SKID if SKID is valid, else loads the input if an input transfer occurs, else OUT becomes empty.
REQ-026 SKID update rule: SKID loads the input when an input transfer occurs while OUT is valid and ex_ready is low; SKID clears when its contents move to OUT.
REQ-027 Ordering: instructions leave in strict arrival order; none is dropped or duplicated unless flushed.
REQ-028 OUT contents shall remain stable while ex_valid is high and ex_ready is low.
REQ-029 Full condition (OUT and SKID valid): id_ready is 0; if_valid is ignored.
REQ-030 Simultaneous input transfer and output transfer with SKID empty: OUT is replaced by the new instruction; throughput is one per cycle.
REQ-031 flush high at an edge: OUT valid and SKID valid both clear; any input transfer in that cycle is discarded; id_ready is 1 the next cycle. flush has priority over every other update.
REQ-032 Data fields of empty entries are don't-care; illegal is only meaningful when ex_valid is 1.

Reset
REQ-033 While rst is low: ex_valid=0, SKID valid=0, id_ready=1, and all decoded outputs, pc and illegal are 0, applied asynchronously.
REQ-034 Reset asserted mid-operation discards held instructions immediately; the first transfer after rst deasserts behaves as from an empty pipeline.

Verification
REQ-035 Reset: rst=0 mid-stream with OUT and SKID full -> ex_valid=0 and id_ready=1 without waiting for a clock edge.
REQ-036 Decode: instr=32'hE000_3FFF (fld=11, special=1), ex_ready=1 -> next cycle: branchInstruction=0000, rd=0000, imm=16'hFFFF, illegal=1.
REQ-037 Decode: instr=32'h4A9C_8005 -> firstLevelDecode=01, specialEncoding=0, secondLevelDecode=0101, aluFunctions=010, rd=0111, rs1=0010, imm=16'h0005, illegal=0.
REQ-038 Backpressure: stream A,B,C back-to-back, ex_ready=0 from cycle 1 -> OUT=A, SKID=B, id_ready=0, C held at input; ex_ready=1 -> outputs A,B,C in order, one per cycle.
REQ-039 Flush: OUT and SKID full, flush=1 with if_valid=1 (D) -> next cycle ex_valid=0, id_ready=1, D never appears at the output.
REQ-040 Throughput: if_valid=1 and ex_ready=1 held for 8 cycles -> 8 instructions out on consecutive cycles; id_ready stays 1 throughout.
